// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage and IF/ID register: PC generation, imem req/ready handshake,
// one-entry skid buffer for decode back-pressure, and branch redirect / flush handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] pc_out,
    output logic [31:0] instruction
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic [31:0] pend_pc, pend_pc_d;
    logic [31:0] skid_pc_p1, skid_pc_d;
    logic [31:0] skid_instr_p1, skid_instr_d;
    logic        vld_p1, vld_d;
    logic [31:0] pc_p1, pc_d;
    logic [31:0] instr_p1, instr_d;

    logic        transfer;
    logic        can_load;
    logic        consumed;

    assign imem_req  = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
    assign imem_addr = word_align(fetch_pc);
    assign transfer  = imem_req && imem_ready;
    assign can_load  = !vld_p1 || !stall;
    assign consumed  = vld_p1 && !stall;

    assign if_valid    = vld_p1;
    assign pc_out      = pc_p1;
    assign instruction = instr_p1;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc;
        pend_pc_d    = pend_pc;
        skid_pc_d    = skid_pc_p1;
        skid_instr_d = skid_instr_p1;
        vld_d        = vld_p1;
        pc_d         = pc_p1;
        instr_d      = instr_p1;

        // A redirect always empties IF/ID; a consumed entry with nothing behind it reads as NOP.
        if (branch_taken || (consumed && !(state_q == HOLD))) begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    if (transfer) begin
                        fetch_pc_d = word_align(branch_target);
                    end else begin
                        pend_pc_d = word_align(branch_target);
                        state_d   = DRAIN;
                    end
                end else if (transfer) begin
                    fetch_pc_d = fetch_pc + PC_STEP;
                    if (can_load) begin
                        vld_d   = 1'b1;
                        pc_d    = imem_addr;
                        instr_d = imem_rdata;
                    end else begin
                        skid_pc_d    = imem_addr;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            DRAIN: begin
                // The outstanding response belongs to the squashed path and is dropped.
                if (branch_taken) begin
                    if (transfer) begin
                        fetch_pc_d = word_align(branch_target);
                        state_d    = FETCH;
                    end else begin
                        pend_pc_d = word_align(branch_target);
                    end
                end else if (transfer) begin
                    fetch_pc_d = pend_pc;
                    state_d    = FETCH;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    fetch_pc_d = word_align(branch_target);
                    state_d    = FETCH;
                end else if (!stall) begin
                    vld_d   = 1'b1;
                    pc_d    = skid_pc_p1;
                    instr_d = skid_instr_p1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // IF/ID stage boundary and fetch control state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            pc_p1    <= 32'h0000_0000;
            instr_p1 <= NOP_INSTR;
        end else begin
            state_q  <= state_d;
            fetch_pc <= fetch_pc_d;
            vld_p1   <= vld_d;
            pc_p1    <= pc_d;
            instr_p1 <= instr_d;
        end
    end

    // Skid and pending-redirect payloads are only meaningful when HOLD/DRAIN says so.
    always_ff @(posedge clk) begin
        pend_pc       <= pend_pc_d;
        skid_pc_p1    <= skid_pc_d;
        skid_instr_p1 <= skid_instr_d;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// queue-based model of the fetch/decode buffer.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] pc_out;
    logic [31:0] instruction;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] key     = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .pc_out(pc_out), .instruction(instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic drive(input logic r, input logic rdy, input logic s, input logic b,
                         input logic [31:0] t);
        reset         = r;
        imem_ready    = rdy;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_rdata    = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        key = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
        tick();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", pc_out); end
        n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL rst_instr got %h exp %h", instruction, NOP); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        key = 32'h0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            n_tests++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_addr got %h exp %h", imem_addr, 32'(4 * i)); end
            tick();
            n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid got %b exp 1", if_valid); end
            n_tests++; if (pc_out !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_pc got %h exp %h", pc_out, 32'(4 * i)); end
            n_tests++; if (instruction !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_instr got %h exp %h", instruction, 32'(4 * i)); end
        end
    endtask

    task automatic test_wait_states();
        key = 32'h5A5A_0000;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_req got %b exp 1", imem_req); end
            n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL ws_addr got %h exp 8", imem_addr); end
            tick();
            n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid got %b exp 0", if_valid); end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL ws_done_valid got %b exp 1", if_valid); end
        n_tests++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL ws_done_pc got %h exp 8", pc_out); end
        n_tests++; if (instruction !== (32'h8 ^ key)) begin n_fail++; $display("FAIL ws_done_instr got %h exp %h", instruction, 32'h8 ^ key); end
    endtask

    task automatic test_stall_skid();
        key = 32'h00A5_0000;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            #1;
            n_tests++; if (imem_req !== (s == 0)) begin n_fail++; $display("FAIL sk_req got %b exp %b", imem_req, (s == 0)); end
            tick();
            n_tests++; if (pc_out !== 32'h0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL sk_hold got pc %h v %b exp pc 0 v 1", pc_out, if_valid); end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL sk_release_req got %b exp 0", imem_req); end
        tick();
        n_tests++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL sk_out_pc got %h exp 4", pc_out); end
        n_tests++; if (instruction !== (32'h4 ^ key)) begin n_fail++; $display("FAIL sk_out_instr got %h exp %h", instruction, 32'h4 ^ key); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL sk_resume got req %b addr %h exp 1 8", imem_req, imem_addr); end
        tick();
        n_tests++; if (pc_out !== 32'h8 || instruction !== (32'h8 ^ key)) begin n_fail++; $display("FAIL sk_next got %h %h exp 8 %h", pc_out, instruction, 32'h8 ^ key); end
    endtask

    task automatic test_branch_drain();
        key = 32'h3C00_0000;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        n_tests++; if (if_valid !== 1'b0 || instruction !== NOP) begin n_fail++; $display("FAIL br_flush got v %b %h exp 0 %h", if_valid, instruction, NOP); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL br_drain_hold got req %b addr %h exp 1 4", imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_discard got %b exp 0", if_valid); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_target_addr got %h exp 100", imem_addr); end
        tick();
        n_tests++; if (pc_out !== 32'h100 || instruction !== (32'h100 ^ key)) begin n_fail++; $display("FAIL br_target_word got %h %h exp 100 %h", pc_out, instruction, 32'h100 ^ key); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h103);
        tick();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_xfer_flush got %b exp 0", if_valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        #1;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_unaligned got %h exp 100", imem_addr); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_addr !== 32'h300) begin n_fail++; $display("FAIL br_latest_wins got %h exp 300", imem_addr); end
        tick();
    endtask

    task automatic test_branch_hold();
        key = 32'h0F0F_0000;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        n_tests++; if (if_valid !== 1'b0 || instruction !== NOP) begin n_fail++; $display("FAIL bh_flush got v %b %h exp 0 %h", if_valid, instruction, NOP); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL bh_target got req %b addr %h exp 1 40", imem_req, imem_addr); end
        tick();
        n_tests++; if (if_valid !== 1'b1 || pc_out !== 32'h40) begin n_fail++; $display("FAIL bh_stall_empty_load got v %b pc %h exp 1 40", if_valid, pc_out); end
    endtask

    task automatic test_reset_mid();
        key = 32'h1234_0000;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            if (mode == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
            else           drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            #1;
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req mode %0d got %b exp 0", mode, imem_req); end
            tick();
            n_tests++; if (if_valid !== 1'b0 || pc_out !== 32'h0 || instruction !== NOP) begin n_fail++; $display("FAIL rm_outs mode %0d got %b %h %h exp 0 0 %h", mode, if_valid, pc_out, instruction, NOP); end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_refetch mode %0d got %b %h exp 1 0", mode, imem_req, imem_addr); end
            tick();
        end
    endtask

    task automatic test_pc_wrap();
        key = 32'h7777_0000;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h exp fffffffc", imem_addr); end
        tick();
        n_tests++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h exp fffffffc", pc_out); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp 0", imem_addr); end
        tick();
    endtask

    task automatic test_random();
        ent_t        mq[$];
        logic [31:0] m_pc, m_pend, tgt;
        logic        m_drain, r, rdy, s, b, exp_req;
        key = $urandom;
        do_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_drain = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 9) < 3);
            b   = ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(r, rdy, s, b, tgt);
            #1;
            exp_req = !r && (mq.size() < 2);
            n_tests++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b exp %b", c, imem_req, exp_req); end
            if (exp_req) begin
                n_tests++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, imem_addr, m_pc); end
            end
            if (r) begin
                mq.delete(); m_pc = 32'h0; m_drain = 1'b0;
            end else if (b) begin
                mq.delete();
                if (exp_req && !rdy) begin m_drain = 1'b1; m_pend = tgt & 32'hFFFF_FFFC; end
                else begin m_drain = 1'b0; m_pc = tgt & 32'hFFFF_FFFC; end
            end else if (m_drain) begin
                if (rdy) begin m_pc = m_pend; m_drain = 1'b0; end
            end else begin
                if (mq.size() > 0 && !s) void'(mq.pop_front());
                if (exp_req && rdy) begin mq.push_back({m_pc, mem_word(m_pc)}); m_pc = m_pc + 32'd4; end
            end
            tick();
            n_tests++; if (if_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, if_valid, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_tests++; if (pc_out !== mq[0].pc || instruction !== mq[0].ins) begin n_fail++; $display("FAIL rnd_word cyc %0d got %h %h exp %h %h", c, pc_out, instruction, mq[0].pc, mq[0].ins); end
            end else begin
                n_tests++; if (instruction !== NOP) begin n_fail++; $display("FAIL rnd_nop cyc %0d got %h exp %h", c, instruction, NOP); end
            end
            if (r) begin
                n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rnd_rst_pc cyc %0d got %h exp 0", c, pc_out); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_skid();
        test_branch_drain();
        test_branch_hold();
        test_reset_mid();
        test_pc_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
